// File: rtl/dmem_port_arbiter_if.sv
// Requester-side bus for the data-BRAM port B arbiter.
// One instance per master (core, debug).
interface dmem_port_arbiter_if;
  logic        req;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, wen, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, wen, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares data-BRAM port B between core load/store and debug master.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed core priority instead of round robin.
module dmem_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  dmem_port_arbiter_if.slave c,
  dmem_port_arbiter_if.slave d,
  output logic               enb,
  output logic [3:0]         web,
  output logic [ADDR_W-1:0]  addrb,
  output logic [31:0]        dib,
  input  logic [31:0]        dob
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

  state_t      state, state_n;
  logic        win, win_n;
  logic        wen_q;
  logic [1:0]  cnt;
  logic [31:0] c_rdata_q, d_rdata_q;
  logic        load, cap;

  logic        s_wen;
  logic [3:0]  s_be;
  logic [31:0] s_addr, s_wdata;
  logic        unused_addr;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  always_comb win_n = ~c.req;
`else
  // last = 1 means debug was granted last, so core is favoured
  logic last;

  always_comb begin
    win_n = d.req;
    if (c.req && d.req) win_n = ~last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last <= 1'b1;
    else if (load) last <= win_n;
  end
`endif

  assign s_wen   = win_n ? d.wen   : c.wen;
  assign s_be    = win_n ? d.be    : c.be;
  assign s_addr  = win_n ? d.addr  : c.addr;
  assign s_wdata = win_n ? d.wdata : c.wdata;

  assign unused_addr = ^{s_addr[31:ADDR_W+2], s_addr[1:0]};

  always_comb begin
    state_n = state;
    load    = 1'b0;
    cap     = 1'b0;
    unique case (state)
      IDLE: begin
        if (c.req || d.req) begin
          load    = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: state_n = wen_q ? IDLE : WAIT;
      WAIT: begin
        if (cnt == CNT_LAST) begin
          cap     = 1'b1;
          state_n = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      win   <= 1'b0;
      wen_q <= 1'b0;
      cnt   <= 2'd0;
    end else begin
      state <= state_n;
      if (load) begin
        win   <= win_n;
        wen_q <= s_wen;
      end
      if (state == WAIT) cnt <= cnt + 2'd1;
      else               cnt <= 2'd0;
    end
  end

  // strobes live exactly one cycle: the ISSUE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enb   <= 1'b0;
      web   <= 4'b0;
      addrb <= '0;
      dib   <= 32'b0;
    end else begin
      enb   <= load;
      web   <= (load && s_wen) ? s_be : 4'b0;
      addrb <= load ? s_addr[ADDR_W+1:2] : '0;
      dib   <= load ? s_wdata : 32'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_rdata_q <= 32'b0;
      d_rdata_q <= 32'b0;
    end else if (cap) begin
      if (win) d_rdata_q <= dob;
      else     c_rdata_q <= dob;
    end
  end

  assign c.gnt    = (state == ISSUE) && !win;
  assign d.gnt    = (state == ISSUE) &&  win;
  assign c.rvalid = (state == RESP)  && !win;
  assign d.rvalid = (state == RESP)  &&  win;
  assign c.rdata  = c_rdata_q;
  assign d.rdata  = d_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed table, corner sequences,
// randomized traffic against a transaction-level reference model.
module tb_dmem_port_arbiter;
  localparam int AW = 12;

  typedef struct packed {
    logic        req;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } drv_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } rsp_t;

  typedef struct {
    int          m;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [AW-1:0] ab;
    logic [31:0] rd;
  } vec_t;

  typedef struct {
    int          m;
    int          due;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  drv_t drv [2][2];
  rsp_t rsp [2][2];

  logic          enb   [2];
  logic [3:0]    web   [2];
  logic [AW-1:0] addrb [2];
  logic [31:0]   dib   [2];
  logic [31:0]   dob   [2];

  dmem_port_arbiter_if c0 ();
  dmem_port_arbiter_if d0 ();
  dmem_port_arbiter_if c3 ();
  dmem_port_arbiter_if d3 ();

  assign {c0.req, c0.wen, c0.be, c0.addr, c0.wdata} = drv[0][0];
  assign {d0.req, d0.wen, d0.be, d0.addr, d0.wdata} = drv[0][1];
  assign {c3.req, c3.wen, c3.be, c3.addr, c3.wdata} = drv[1][0];
  assign {d3.req, d3.wen, d3.be, d3.addr, d3.wdata} = drv[1][1];
  assign rsp[0][0] = {c0.gnt, c0.rvalid, c0.rdata};
  assign rsp[0][1] = {d0.gnt, d0.rvalid, d0.rdata};
  assign rsp[1][0] = {c3.gnt, c3.rvalid, c3.rdata};
  assign rsp[1][1] = {d3.gnt, d3.rvalid, d3.rdata};

  dmem_port_arbiter #(.ADDR_W(AW), .RD_LAT(1)) u0 (
    .clk(clk), .rst(rst), .c(c0), .d(d0),
    .enb(enb[0]), .web(web[0]), .addrb(addrb[0]),
    .dib(dib[0]), .dob(dob[0])
  );

  dmem_port_arbiter #(.ADDR_W(AW), .RD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .c(c3), .d(d3),
    .enb(enb[1]), .web(web[1]), .addrb(addrb[1]),
    .dib(dib[1]), .dob(dob[1])
  );

  // BRAM models: dob is garbage except exactly RD_LAT cycles after enb
  logic [31:0] bram0 [4096];
  logic [31:0] bram3 [4096];
  logic [31:0] p3a, p3b;

  always @(posedge clk) begin
    dob[0] <= enb[0] ? bram0[addrb[0]] : 32'hBAD0_0001;
    if (enb[0])
      for (int b = 0; b < 4; b++)
        if (web[0][b]) bram0[addrb[0]][8*b +: 8] <= dib[0][8*b +: 8];
  end

  always @(posedge clk) begin
    p3a    <= enb[1] ? bram3[addrb[1]] : 32'hBAD0_0003;
    p3b    <= p3a;
    dob[1] <= p3b;
    if (enb[1])
      for (int b = 0; b < 4; b++)
        if (web[1][b]) bram3[addrb[1]][8*b +: 8] <= dib[1][8*b +: 8];
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
    end
  endfunction

  task automatic chk_zero(input int i);
    chk("z_enb",   32'(enb[i]), 0);
    chk("z_web",   32'(web[i]), 0);
    chk("z_addrb", 32'(addrb[i]), 0);
    chk("z_dib",   dib[i], 0);
    chk("z_cgnt",  32'(rsp[i][0].gnt), 0);
    chk("z_dgnt",  32'(rsp[i][1].gnt), 0);
    chk("z_crv",   32'(rsp[i][0].rvalid), 0);
    chk("z_drv",   32'(rsp[i][1].rvalid), 0);
    chk("z_crd",   rsp[i][0].rdata, 0);
    chk("z_drd",   rsp[i][1].rdata, 0);
  endtask

  task automatic rst_pulse();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // one access from an otherwise idle master; checks strobes and response
  task automatic do_access(
    input int i, input int m, input logic wen, input logic [3:0] be,
    input logic [31:0] addr, input logic [31:0] wdata,
    input int exp_wait, input logic [31:0] exp_rd, input logic [AW-1:0] exp_ab,
    output int gcyc, output int rcyc
  );
    int w, lat, o, nrv;
    lat = (i == 0) ? 1 : 3;
    o = 1 - m;
    gcyc = -1;
    rcyc = -1;
    @(posedge clk); #1;
    drv[i][m] = '{1'b1, wen, be, addr, wdata};
    w = -1;
    do begin @(negedge clk); w++; end while (!rsp[i][m].gnt && w < 50);
    if (!rsp[i][m].gnt) begin
      chk("gnt_timeout", 0, 1);
      drv[i][m].req = 1'b0;
      return;
    end
    gcyc = cyc;
    if (exp_wait >= 0) chk("gnt_lat", w, exp_wait);
    chk("other_gnt", 32'(rsp[i][o].gnt), 0);
    chk("enb", 32'(enb[i]), 1);
    chk("addrb", 32'(addrb[i]), 32'(exp_ab));
    chk("web", 32'(web[i]), wen ? 32'(be) : 0);
    if (wen) chk("dib", dib[i], wdata);
    @(posedge clk); #1;
    drv[i][m].req = 1'b0;
    nrv = 0;
    for (int k = 0; k < lat + 2; k++) begin
      @(negedge clk);
      if (rsp[i][o].rvalid) chk("other_rvalid", 1, 0);
      if (rsp[i][m].rvalid) begin
        nrv++;
        if (rcyc < 0) rcyc = cyc;
      end
    end
    chk("rvalid_cnt", nrv, wen ? 0 : 1);
    if (!wen && nrv > 0) begin
      chk("rvalid_lat", rcyc - gcyc, lat + 1);
      chk("rdata", rsp[i][m].rdata, exp_rd);
    end
  endtask

  int order [$];

  task automatic rr_drv(input int m);
    int w;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      drv[0][m] = '{1'b1, 1'b1, 4'hF, 32'h400 + 32'(16*m + 4*k), 32'hA000_0000 + 32'(k)};
      w = 0;
      do begin @(negedge clk); w++; end while (!rsp[0][m].gnt && w < 50);
      if (rsp[0][m].gnt) order.push_back(m);
      else chk("rr_timeout", 0, 1);
    end
    @(posedge clk); #1;
    drv[0][m].req = 1'b0;
  endtask

  // reference model for random traffic on u0
  logic [31:0] refm [8];
  int          ridx [2];
  exp_t        expq [$];
  int          last_g;
  logic        prev_req [2];
  bit          mon_en = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp[0][0].gnt && rsp[0][1].gnt) chk("dual_gnt", 1, 0);
      if (enb[0] && !rsp[0][0].gnt && !rsp[0][1].gnt) chk("enb_no_gnt", 1, 0);
      for (int m = 0; m < 2; m++) begin
        if (rsp[0][m].gnt) begin
          chk("gnt_had_req", 32'(prev_req[m]), 1);
          if (prev_req[0] && prev_req[1]) chk("rr_pick", m, 1 - last_g);
          last_g = m;
          chk("r_enb", 32'(enb[0]), 1);
          chk("r_addrb", 32'(addrb[0]), 32'h300 + 32'(ridx[m]));
          chk("r_web", 32'(web[0]), drv[0][m].wen ? 32'(drv[0][m].be) : 0);
          if (drv[0][m].wen) begin
            chk("r_dib", dib[0], drv[0][m].wdata);
            for (int b = 0; b < 4; b++)
              if (drv[0][m].be[b]) refm[ridx[m]][8*b +: 8] = drv[0][m].wdata[8*b +: 8];
          end else begin
            expq.push_back('{m, cyc + 2, refm[ridx[m]]});
          end
        end
      end
      for (int m = 0; m < 2; m++) begin
        if (rsp[0][m].rvalid) begin
          if (expq.size() == 0) chk("spurious_rvalid", 1, 0);
          else begin
            chk("rv_who", m, expq[0].m);
            chk("rv_cyc", cyc, expq[0].due);
            chk("rv_data", rsp[0][m].rdata, expq[0].data);
            void'(expq.pop_front());
          end
        end
      end
      if (expq.size() > 0 && expq[0].due < cyc) begin
        chk("missed_rvalid", 0, 1);
        void'(expq.pop_front());
      end
      for (int m = 0; m < 2; m++) prev_req[m] = drv[0][m].req;
    end
  end

  task automatic rand_drv(input int m, input int n);
    int w, gap;
    logic [31:0] up;
    for (int k = 0; k < n; k++) begin
      gap = int'($urandom_range(0, 2));
      if (gap > 0 && k > 0) begin
        @(posedge clk); #1;
        drv[0][m].req = 1'b0;
        repeat (gap - 1) @(posedge clk);
      end
      @(posedge clk); #1;
      ridx[m] = int'($urandom_range(0, 7));
      up = $urandom() & 32'hFFFF_C000;
      drv[0][m] = '{1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    up | ((32'h300 + 32'(ridx[m])) << 2) | ($urandom() & 32'h3),
                    $urandom()};
      w = 0;
      do begin @(negedge clk); w++; end while (!rsp[0][m].gnt && w < 100);
      if (!rsp[0][m].gnt) chk("rand_timeout", 0, 1);
    end
    @(posedge clk); #1;
    drv[0][m].req = 1'b0;
  endtask

  vec_t tbl [10];
  int   g, r, g6, r6, wc, cg, nrv;

  initial begin
    for (int i = 0; i < 2; i++)
      for (int m = 0; m < 2; m++) drv[i][m] = '0;
    for (int a = 0; a < 4096; a++) begin
      bram0[a] = 32'h0;
      bram3[a] = 32'h0;
    end
    for (int a = 0; a < 8; a++) refm[a] = 32'h0;

    tbl[0] = '{0, 1'b1, 4'b0100, 32'h0000_0010, 32'h00AB_0000, 12'h004, 32'h0};
    tbl[1] = '{0, 1'b0, 4'b0000, 32'h0000_0010, 32'h0,         12'h004, 32'h00AB_0000};
    tbl[2] = '{1, 1'b1, 4'b1111, 32'hFFFF_FFFC, 32'h1122_3344, 12'hFFF, 32'h0};
    tbl[3] = '{1, 1'b1, 4'b0000, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 12'hFFF, 32'h0};
    tbl[4] = '{1, 1'b0, 4'b0000, 32'hFFFF_FFFC, 32'h0,         12'hFFF, 32'h1122_3344};
    tbl[5] = '{1, 1'b1, 4'b1111, 32'h0000_0020, 32'hCAFE_BABE, 12'h008, 32'h0};
    tbl[6] = '{0, 1'b0, 4'b1111, 32'h0000_0020, 32'h0,         12'h008, 32'hCAFE_BABE};
    tbl[7] = '{0, 1'b1, 4'b0011, 32'h0000_0020, 32'h0000_1234, 12'h008, 32'h0};
    tbl[8] = '{1, 1'b0, 4'b0000, 32'h0000_0020, 32'h0,         12'h008, 32'hCAFE_1234};
    tbl[9] = '{0, 1'b0, 4'b0000, 32'h0000_4010, 32'h0,         12'h004, 32'h00AB_0000};

    repeat (2) @(negedge clk);
    chk_zero(0);
    chk_zero(1);
    @(negedge clk); rst = 1'b0;

    for (int k = 0; k < 10; k++)
      do_access(0, tbl[k].m, tbl[k].wen, tbl[k].be, tbl[k].addr, tbl[k].wdata,
                1, tbl[k].rd, tbl[k].ab, g, r);

    // RD_LAT=3 read; core request landing in WAIT waits for RESP
    do_access(1, 0, 1'b1, 4'hF, 32'h40, 32'h5A5A_1234, 1, 32'h0, 12'h010, g, r);
    cg = -100;
    fork
      do_access(1, 1, 1'b0, 4'h0, 32'h40, 32'h0, 1, 32'h5A5A_1234, 12'h010, g6, r6);
      begin
        wc = 0;
        do begin @(negedge clk); wc++; end while (!rsp[1][1].gnt && wc < 50);
        @(posedge clk); #1;
        drv[1][0] = '{1'b1, 1'b1, 4'hF, 32'h44, 32'h0000_0077};
        wc = 0;
        do begin @(negedge clk); wc++; end while (!rsp[1][0].gnt && wc < 50);
        if (rsp[1][0].gnt) begin
          cg = cyc;
          chk("late_addrb", 32'(addrb[1]), 32'h011);
        end
        @(posedge clk); #1;
        drv[1][0].req = 1'b0;
      end
    join
    chk("late_gnt", cg - r6, 2);

    // round robin with both masters saturating, from reset
    rst_pulse();
    fork
      rr_drv(0);
      rr_drv(1);
    join
    chk("rr_count", order.size(), 8);
    for (int j = 0; j < order.size(); j++)
      chk($sformatf("rr_order%0d", j), order[j], j % 2);

    // reset while a debug read sits in WAIT
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    drv[0][1] = '{1'b1, 1'b0, 4'h0, 32'h20, 32'h0};
    wc = 0;
    do begin @(negedge clk); wc++; end while (!rsp[0][1].gnt && wc < 50);
    chk("t4_gnt", 32'(rsp[0][1].gnt), 1);
    @(posedge clk); #1;
    drv[0][1].req = 1'b0;
    #2 rst = 1'b1;
    #1 chk_zero(0);
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    nrv = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp[0][1].rvalid) nrv++;
    end
    chk("t4_no_rvalid", nrv, 0);
    chk("t4_rdata", rsp[0][1].rdata, 0);
    do_access(0, 0, 1'b0, 4'h0, 32'h20, 32'h0, 1, 32'hCAFE_1234, 12'h008, g, r);

    // randomized two-master traffic
    rst_pulse();
    last_g = 1;
    prev_req[0] = 1'b0;
    prev_req[1] = 1'b0;
    mon_en = 1;
    fork
      rand_drv(0, 40);
      rand_drv(1, 40);
    join
    wc = 0;
    while (expq.size() > 0 && wc < 10) begin @(negedge clk); wc++; end
    repeat (2) @(negedge clk);
    mon_en = 0;
    chk("drain", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
